// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   fetch_state_t : fetch FSM states (FILL, RUN, HALTED)
//   FETCH_D/W/CW  : default address, instruction and counter widths
//   HALT_INSTR    : encoding that ends the program (also used by decoder/assembler checks)
package fetch_pkg;

  typedef enum logic [1:0] {
    FILL,
    RUN,
    HALTED
  } fetch_state_t;

  localparam int FETCH_D  = 12;
  localparam int FETCH_W  = 9;
  localparam int FETCH_CW = 16;

  localparam logic [FETCH_W-1:0] HALT_INSTR = '1;

endpackage

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage downstream of the program counter.
// Presents prog_ctr to a 1-cycle synchronous ROM, registers the returned word
// with its PC for decode, squashes wrong-path fetches on a taken jump, and
// freezes on the halt instruction.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   prog_ctr [D]      current program counter
//   jump_en           taken-jump strobe (same one the PC sees)
//   imem_addr [D]     ROM address, combinational copy of prog_ctr
//   imem_rdata [W]    ROM data for last cycle's address
//   instr [W]         registered instruction
//   instr_pc [D]      PC that instr came from
//   instr_valid       instr/instr_pc are live
//   done              halt reached, sticky until reset
//   fetch_count [CW]  delivered instructions, saturating
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int D  = FETCH_D,
  parameter int W  = FETCH_W,
  parameter int CW = FETCH_CW,
  parameter logic [W-1:0] HALT_INSTR = {W{1'b1}}
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [D-1:0]  prog_ctr,
  input  logic          jump_en,
  output logic [D-1:0]  imem_addr,
  input  logic [W-1:0]  imem_rdata,
  output logic [W-1:0]  instr,
  output logic [D-1:0]  instr_pc,
  output logic          instr_valid,
  output logic          done,
  output logic [CW-1:0] fetch_count
);

  fetch_state_t state, state_nxt;

  // S1: address handed to the ROM last cycle, data arrives this cycle
  logic [D-1:0] s1_pc;
  logic         s1_valid;

  logic at_halt;
  assign at_halt   = instr_valid && (instr == HALT_INSTR);
  assign imem_addr = prog_ctr;

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    state_nxt = RUN;
      RUN:     if (at_halt) state_nxt = HALTED;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FILL;
      s1_pc       <= '0;
      s1_valid    <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      done        <= 1'b0;
      fetch_count <= '0;
    end else begin
      state <= state_nxt;

      // counts the halt itself too; instr_valid is always 0 once halted
      if (instr_valid && (fetch_count != '1))
        fetch_count <= fetch_count + 1'b1;

      case (state)
        FILL: begin
          s1_pc       <= prog_ctr;
          s1_valid    <= !jump_en;
          instr_valid <= 1'b0;
        end
        RUN: begin
          if (at_halt) begin
            // halt beats a same-cycle jump; output fields freeze
            done        <= 1'b1;
            instr_valid <= 1'b0;
          end else begin
            // a taken jump kills both in-flight slots; fields load anyway
            s1_pc       <= prog_ctr;
            s1_valid    <= !jump_en;
            instr       <= imem_rdata;
            instr_pc    <= s1_pc;
            instr_valid <= s1_valid && !jump_en;
          end
        end
        HALTED: instr_valid <= 1'b0;
        default: instr_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam int D = 12, W = 9, CW = 16, MAXC = 4096;
  localparam logic [W-1:0] HALT = '1;

  logic          clk = 1'b0;
  logic          reset, jump_en;
  logic [D-1:0]  prog_ctr, imem_addr, instr_pc;
  logic [W-1:0]  imem_rdata, instr;
  logic          instr_valid, done;
  logic [CW-1:0] fetch_count;
  // narrow-counter build, same stimulus
  logic [D-1:0]  imem_addr3, instr_pc3;
  logic [W-1:0]  instr3;
  logic          instr_valid3, done3;
  logic [2:0]    fetch_count3;

  always #5 clk = ~clk;

  fetch_stage #(.D(D), .W(W), .CW(CW)) dut (
    .clk(clk), .reset(reset), .prog_ctr(prog_ctr), .jump_en(jump_en),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .instr(instr),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .done(done),
    .fetch_count(fetch_count));

  fetch_stage #(.D(D), .W(W), .CW(3)) dut3 (
    .clk(clk), .reset(reset), .prog_ctr(prog_ctr), .jump_en(jump_en),
    .imem_addr(imem_addr3), .imem_rdata(imem_rdata), .instr(instr3),
    .instr_pc(instr_pc3), .instr_valid(instr_valid3), .done(done3),
    .fetch_count(fetch_count3));

  // 1-cycle synchronous ROM
  logic [W-1:0] rom [0:(1<<D)-1];
  always @(posedge clk) imem_rdata <= rom[imem_addr];

  int checks = 0, errors = 0;
  int k;

  // per-cycle history: reset, jump, target, pc presented, rom word at that pc
  bit           hr [0:MAXC];
  bit           hj [0:MAXC];
  logic [D-1:0] ht [0:MAXC];
  logic [D-1:0] hp [0:MAXC];
  logic [W-1:0] hi [0:MAXC];
  bit           halted;
  int           cnt;
  bit           ev;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, k, act, exp);
    end
  endtask

  function automatic int sat(input int c, input int m);
    return (c > m) ? m : c;
  endfunction

  // Reference: an address presented at cycle c shows up valid at c+2 unless
  // a reset or jump occurred at c or c+1, or the halt was already delivered.
  task automatic model_check();
    ev = !halted && k >= 3 && !hr[k-1] && !hr[k-2] && !hj[k-1] && !hj[k-2];
    chk("valid", instr_valid, ev);
    chk("done", done, halted);
    chk("count", fetch_count, sat(cnt, (1<<CW)-1));
    chk("count3", fetch_count3, sat(cnt, 7));
    chk("imem_addr", imem_addr, prog_ctr);
    if (ev) begin
      chk("pc", instr_pc, hp[k-2]);
      chk("instr", instr, hi[k-2]);
    end
    if (hr[k-1]) begin
      chk("rst_pc", instr_pc, 0);
      chk("rst_instr", instr, 0);
    end
    if (hr[k]) begin
      halted = 1'b0;
      cnt    = 0;
    end else if (ev) begin
      cnt++;
      if (hi[k-2] == HALT) halted = 1'b1;
    end
  endtask

  // One cycle: inputs driven just after the edge, outputs sampled at negedge.
  // prog_ctr follows an upstream PC: reset->0, jump->target, else +1.
  task automatic step(input bit r, input bit j, input logic [D-1:0] t);
    logic [D-1:0] pcn;
    @(posedge clk); #1;
    k++;
    pcn = hr[k-1] ? '0 : (hj[k-1] ? ht[k-1] : hp[k-1] + 1'b1);
    reset = r; jump_en = j; prog_ctr = pcn;
    hr[k] = r; hj[k] = j; ht[k] = t; hp[k] = pcn; hi[k] = rom[pcn];
    @(negedge clk);
    if (k >= 2) model_check();
  endtask

  task automatic rom_clean();
    logic [W-1:0] v;
    for (int i = 0; i < (1<<D); i++) begin
      v = W'(i + 5);
      rom[i] = (v == HALT) ? '0 : v;
    end
  endtask

  typedef struct {
    bit r; bit j; logic [D-1:0] t;
    bit ev; logic [D-1:0] pc; logic [W-1:0] ins; int c;
  } vec_t;
  vec_t tbl [16];

  function automatic vec_t mv(bit r, bit j, int t, bit e, int pc, int ins, int c);
    vec_t v;
    v.r = r; v.j = j; v.t = D'(t); v.ev = e; v.pc = D'(pc); v.ins = W'(ins); v.c = c;
    return v;
  endfunction

  initial begin
    reset = 1'b1; jump_en = 1'b0; prog_ctr = '0;
    k = 0; hr[0] = 1'b1; hj[0] = 1'b0; ht[0] = '0; hp[0] = '0; hi[0] = '0;
    halted = 1'b0; cnt = 0;
    rom_clean();
    step(1, 0, 0);

    // straight line, single jump to 0x20, back-to-back jumps 0x10 then 0x40
    tbl[0]  = mv(1, 0, 0,    0, 0,    0,    0);
    tbl[1]  = mv(0, 0, 0,    0, 0,    0,    0);
    tbl[2]  = mv(0, 0, 0,    0, 0,    0,    0);
    tbl[3]  = mv(0, 0, 0,    1, 0,    5,    0);
    tbl[4]  = mv(0, 0, 0,    1, 1,    6,    1);
    tbl[5]  = mv(0, 0, 0,    1, 2,    7,    2);
    tbl[6]  = mv(0, 1, 'h20, 1, 3,    8,    3);
    tbl[7]  = mv(0, 0, 0,    0, 0,    0,    4);
    tbl[8]  = mv(0, 0, 0,    0, 0,    0,    4);
    tbl[9]  = mv(0, 0, 0,    1, 'h20, 'h25, 4);
    tbl[10] = mv(0, 1, 'h10, 1, 'h21, 'h26, 5);
    tbl[11] = mv(0, 1, 'h40, 0, 0,    0,    6);
    tbl[12] = mv(0, 0, 0,    0, 0,    0,    6);
    tbl[13] = mv(0, 0, 0,    0, 0,    0,    6);
    tbl[14] = mv(0, 0, 0,    1, 'h40, 'h45, 6);
    tbl[15] = mv(0, 0, 0,    1, 'h41, 'h46, 7);
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].r, tbl[i].j, tbl[i].t);
      chk($sformatf("tbl%0d_valid", i), instr_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_done", i), done, 0);
      chk($sformatf("tbl%0d_count", i), fetch_count, tbl[i].c);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_pc", i), instr_pc, tbl[i].pc);
        chk($sformatf("tbl%0d_instr", i), instr, tbl[i].ins);
      end
    end

    // halt at PC 6, then jumps must be ignored
    rom[6] = HALT;
    step(1, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 0);
    chk("halt_valid", instr_valid, 1);
    chk("halt_pc", instr_pc, 6);
    for (int i = 0; i < 20; i++) begin
      step(0, (i % 3) == 0, D'($urandom));
      chk("halted_valid", instr_valid, 0);
      chk("halted_done", done, 1);
      chk("halted_count", fetch_count, 7);
    end
    // reset out of HALTED
    step(1, 0, 0);
    step(0, 0, 0);
    chk("rsth_done", done, 0);
    chk("rsth_valid", instr_valid, 0);
    chk("rsth_count", fetch_count, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("rsth_first_valid", instr_valid, 1);
    chk("rsth_first_pc", instr_pc, 0);

    // long straight run saturates the 3-bit counter, then reset mid-stream
    rom_clean();
    step(1, 0, 0);
    for (int i = 0; i < 14; i++) step(0, 0, 0);
    chk("sat_count3", fetch_count3, 7);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("rstm_done", done, 0);
    chk("rstm_valid", instr_valid, 0);
    chk("rstm_count", fetch_count, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("rstm_first_valid", instr_valid, 1);
    chk("rstm_first_pc", instr_pc, 0);

    // random program with occasional halts, jumps and resets
    for (int i = 0; i < (1<<D); i++) begin
      logic [W-1:0] v;
      v = W'($urandom);
      if (v == HALT) v = '0;
      rom[i] = ($urandom_range(0, 39) == 0) ? HALT : v;
    end
    step(1, 0, 0);
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 59) == 0, $urandom_range(0, 4) == 0, D'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage sitting directly downstream of the program counter. It drives the instruction-memory address from `prog_ctr` and captures the synchronous ROM's read data into a registered instruction/PC pair for decode. It squashes wrong-path instructions when a jump is taken and detects the halt instruction, freezing output and raising `done`. It also keeps a saturating count of delivered instructions for the run summary.

## Interface
- `D`, 12, instruction address width (matches program counter width)
- `W`, 9, instruction width
- `CW`, 16, fetch counter width
- `HALT_INSTR`, all ones (W bits), encoding that terminates the program

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `prog_ctr`  in  D  current program counter value
- `jump_en`  in  1  same jump strobe that is fed to the program counter; marks in-flight fetches as wrong-path
- `imem_addr`  out  D  instruction memory address, combinational copy of `prog_ctr`
- `imem_rdata`  in  W  ROM data for the address presented on the previous cycle
- `instr`  out  W  registered instruction to decode
- `instr_pc`  out  D  address `instr` was fetched from
- `instr_valid`  out  1  `instr` and `instr_pc` are a live instruction
- `done`  out  1  halt instruction reached, sticky until reset
- `fetch_count`  out  CW  number of valid instructions delivered, saturating

## Operation
- Two pipeline slots:
  - S1, ROM in flight: `s1_pc`, `s1_valid`.
  - S2, output register: `instr`, `instr_pc`, `instr_valid`.
- Each clock in RUN:
  - `s1_pc <= prog_ctr` and `s1_valid <= 1`.
  - `instr <= imem_rdata`, `instr_pc <= s1_pc`, `instr_valid <= s1_valid`.
- Squash: at an edge where `jump_en = 1`, both `s1_valid` and `instr_valid` are written 0. Data and PC fields still load, but their content is don't-care. The address presented at the following cycle is the jump target and flows normally.
- FSM states: FILL, RUN, HALTED.
  - FILL is the single cycle after reset. `s1_valid <= 1`, S2 stays invalid; next state is RUN.
  - RUN goes to HALTED at the edge where `instr_valid = 1` and `instr = HALT_INSTR`.
  - In HALTED: `done = 1`, `instr_valid` is forced 0 from the next edge on, S1 is ignored, `jump_en` is ignored, and `fetch_count` is frozen.
  - HALTED is left only by reset.
- `fetch_count` increments by 1 at every edge where `instr_valid = 1`; this includes the HALT instruction itself. It holds at 2^CW−1.
- `done` goes high at the edge that enters HALTED.

## Timing
- Reset values: `instr = 0`, `instr_pc = 0`, `instr_valid = 0`, `done = 0`, `fetch_count = 0`, `s1_valid = 0`, state FILL. `imem_addr` follows `prog_ctr` with no reset of its own.
- Latency: the address on `prog_ctr` at cycle t gives the matching `instr`/`instr_pc` with `instr_valid = 1` at cycle t+2, absent squash.
- The first valid instruction (PC 0) appears 2 cycles after reset deasserts.
- `jump_en` at cycle t:
  - `instr_valid = 0` at t+1 and t+2.
  - The target instruction is valid at t+3.
  - The jump instruction itself, on the output at t, is unaffected.
- Back-to-back `jump_en` at t and t+1: each edge squashes again, and the second target is valid at t+4.
- HALT on the output at cycle t: `done = 1` and `instr_valid = 0` from t+1 onward, whatever `jump_en` or `imem_rdata` do.
- `jump_en` in the same cycle that HALT is on the output: halt wins and the state goes to HALTED.
- Reset asserted mid-run or in HALTED: all outputs return to reset values at that edge, and fetch restarts in FILL.
- Address wrap: `instr_pc` carries whatever `prog_ctr` supplied, so D-bit wrap of PC needs no special handling here.

## Structure
- Package `fetch_pkg`:
  - State enum `fetch_state_t` {FILL, RUN, HALTED}.
  - Default `W`, `D`, `CW` constants.
  - `HALT_INSTR` constant, shared with the decoder and assembler checks.
- No sub-module: a single always_ff for the slots, FSM and counter, plus a combinational `imem_addr` assignment.
- The instruction ROM is external. The bench supplies a 1-cycle synchronous ROM model.

## Test plan
- Straight-line fetch:
  - Stimulus: reset, ROM[i] = i+5, PC free-running from 0.
  - Required: `instr_valid` first high 2 cycles after reset release with `instr = 5`, `instr_pc = 0`; then `instr = 6`, `instr_pc = 1`, and so on.
  - Required: `fetch_count` = 4 after 4 valid cycles.
- Single jump:
  - Stimulus: pulse `jump_en` while `instr_pc = 3`, with target 0x20.
  - Required: the next two cycles have `instr_valid = 0`; then `instr_pc = 0x20` with `instr = ROM[0x20]`; no instruction from PC 4 or 5 is ever valid.
- Back-to-back jumps:
  - Stimulus: `jump_en` on two consecutive cycles, targets 0x10 then 0x40.
  - Required: PC 0x10 is never valid; 0x40 is valid 3 cycles after the second pulse.
- Halt:
  - Stimulus: ROM[6] = all ones.
  - Required: `instr_valid` at PC 6, then `done = 1` at the next edge; `instr_valid` stays 0 and `fetch_count` = 7 for 20 cycles, even when `jump_en` is pulsed.
- Reset mid-operation:
  - Stimulus: assert reset while HALTED and, separately, mid-stream.
  - Required: next edge gives `done = 0`, `instr_valid = 0`, `fetch_count = 0`; PC 0 is valid 2 cycles after release.
- Counter saturation:
  - Stimulus: build with `CW = 3` and run 10 valid fetches.
  - Required: `fetch_count` holds at 7.
